// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: two-line raster buffer that emits vertically aligned
// (bottom, middle, top) pixel triplets for the Sobel window stage.
// One triplet per accepted pixel from row 1 onward, then a COLS-long flush of
// the last row with a zero bottom pixel, so every frame yields ROWS*COLS triplets.
// Optional macro SOBEL_LB_FRAME_SYNC_EN adds sof_i, which resynchronises the
// frame position to pixel (0,0) on any accept.
module sobel_line_buffer #(
    parameter int COLS = 640,
    parameter int ROWS = 480,
    parameter int DW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] pixel_i,
    input  logic          valid_i,
`ifdef SOBEL_LB_FRAME_SYNC_EN
    input  logic          sof_i,
`endif
    output logic          ready_o,
    output logic [DW-1:0] d0_o,
    output logic [DW-1:0] d1_o,
    output logic [DW-1:0] d2_o,
    output logic          done_o
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {PRIME, STREAM, FLUSH} state_t;

    state_t        state, next_state, eff_state;
    logic [CW-1:0] col, eff_col, fcol;
    logic [RW-1:0] row, eff_row;
    logic          accept, sof_acc;
    logic          col_last, row_last, fcol_last;
    logic          emit_stream, emit_flush;

    // Line storage: line1 = previous row, line2 = the row before that.
    // Not reset; row-1 zero-forcing hides stale contents.
    logic [DW-1:0] line1 [COLS];
    logic [DW-1:0] line2 [COLS];

    assign accept = valid_i && ready_o;

`ifdef SOBEL_LB_FRAME_SYNC_EN
    assign sof_acc = accept && sof_i;
`else
    assign sof_acc = 1'b0;
`endif

    // A start-of-frame accept behaves exactly like pixel (0,0) in PRIME.
    assign eff_state = sof_acc ? PRIME : state;
    assign eff_col   = sof_acc ? '0 : col;
    assign eff_row   = sof_acc ? '0 : row;

    assign col_last  = (eff_col == CW'(COLS - 1));
    assign row_last  = (eff_row == RW'(ROWS - 1));
    assign fcol_last = (fcol == CW'(COLS - 1));

    // Next-state and strobe selection; defaults first.
    always_comb begin
        next_state  = eff_state;
        emit_stream = 1'b0;
        emit_flush  = 1'b0;
        case (eff_state)
            PRIME: begin
                if (accept && col_last) next_state = STREAM;
            end
            STREAM: begin
                emit_stream = accept;
                if (accept && col_last && row_last) next_state = FLUSH;
            end
            FLUSH: begin
                emit_flush = 1'b1;
                if (fcol_last) next_state = PRIME;
            end
            default: next_state = PRIME;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= PRIME;
        else     state <= next_state;
    end

    // Raster position counters advance on accept; flush column runs in FLUSH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col  <= '0;
            row  <= '0;
            fcol <= '0;
        end else begin
            if (accept) begin
                col <= col_last ? '0 : eff_col + CW'(1);
                if (col_last) row <= row_last ? '0 : eff_row + RW'(1);
                else          row <= eff_row;
            end
            if (emit_flush) fcol <= fcol_last ? '0 : fcol + CW'(1);
        end
    end

    // ready_o is registered off the next state so it drops for the flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ready_o <= 1'b1;
        else     ready_o <= (next_state != FLUSH);
    end

    // Line shift on accept: read-before-write at the current column.
    always_ff @(posedge clk) begin
        if (accept) begin
            line2[eff_col] <= line1[eff_col];
            line1[eff_col] <= pixel_i;
        end
    end

    // Registered triplet outputs; values hold between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_o <= 1'b0;
            d0_o   <= '0;
            d1_o   <= '0;
            d2_o   <= '0;
        end else begin
            done_o <= emit_stream || emit_flush;
            if (emit_stream) begin
                d0_o <= pixel_i;
                d1_o <= line1[eff_col];
                d2_o <= (eff_row == RW'(1)) ? '0 : line2[eff_col];
            end else if (emit_flush) begin
                d0_o <= '0;
                d1_o <= line1[fcol];
                d2_o <= line2[fcol];
            end
        end
    end

endmodule

// File: tb/tb_sobel_line_buffer.sv
// Scoreboard bench for sobel_line_buffer (ROWS=COLS=4): driver pushes expected
// triplets from a frame-array model, a negedge monitor pops on done_o.
module tb_sobel_line_buffer;

    localparam int COLS = 4;
    localparam int ROWS = 4;
    localparam int DW   = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] pixel_i = '0;
    logic          valid_i = 1'b0;
    logic          sof_i = 1'b0;
    logic          ready_o, done_o;
    logic [DW-1:0] d0_o, d1_o, d2_o;

    int errors = 0;
    int checks = 0;
    int strobes = 0;
    int low_run = 0;
    logic [3*DW-1:0] q[$];
    int fr [ROWS][COLS];

    sobel_line_buffer #(.COLS(COLS), .ROWS(ROWS), .DW(DW)) dut (
        .clk(clk), .rst(rst), .pixel_i(pixel_i), .valid_i(valid_i),
`ifdef SOBEL_LB_FRAME_SYNC_EN
        .sof_i(sof_i),
`endif
        .ready_o(ready_o), .d0_o(d0_o), .d1_o(d1_o), .d2_o(d2_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop/compare on each strobe; measure each ready_o low window.
    always @(negedge clk) begin
        if (!rst) begin
            if (done_o) begin
                strobes++;
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_strobe: got %0h expected none", {d0_o, d1_o, d2_o});
                end else begin
                    chk("triplet", {d0_o, d1_o, d2_o}, q.pop_front());
                end
            end
            if (!ready_o) low_run++;
            else if (low_run > 0) begin
                chk("ready_low_cycles", low_run, COLS);
                low_run = 0;
            end
        end
    end

    // Reference: triplet for accepted pixel (r,c) is column c of rows r, r-1, r-2.
    task automatic model_accept(input int r, input int c, input int v);
        fr[r][c] = v;
        if (r >= 1) q.push_back({DW'(v), DW'(fr[r-1][c]), (r == 1) ? DW'(0) : DW'(fr[r-2][c])});
        if (r == ROWS-1 && c == COLS-1)
            for (int k = 0; k < COLS; k++)
                q.push_back({DW'(0), DW'(fr[ROWS-1][k]), DW'(fr[ROWS-2][k])});
    endtask

    // Drive one frame; stop_after>=0 ends early (no flush expected).
    task automatic send_frame(input bit rnd, input int idle, input int stop_after, input bit sof_first);
        int n = 0;
        int v, t;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (n == stop_after) return;
                v = rnd ? int'($urandom_range(255)) : 16*r + c;
                while (int'($urandom_range(99)) < idle) begin
                    valid_i = 1'b0;
                    @(posedge clk); #1;
                end
                valid_i = 1'b1;
                pixel_i = DW'(v);
                sof_i   = sof_first && (n == 0);
                t = 0;
                while (!ready_o && t < 100) begin
                    @(posedge clk); #1; t++;
                end
                if (t >= 100) begin
                    chk("ready_timeout", 0, 1);
                    valid_i = 1'b0;
                    return;
                end
                @(posedge clk);
                model_accept(r, c, v);
                #1;
                valid_i = 1'b0;
                sof_i   = 1'b0;
                n++;
            end
        end
        // Hold junk on the input during the flush; it must be ignored.
        valid_i = 1'b1;
        pixel_i = 8'hAA;
        t = 0;
        while (!ready_o && t < 50) begin
            @(posedge clk); #1; t++;
        end
        valid_i = 1'b0;
        if (t >= 50) chk("flush_timeout", 0, 1);
    endtask

    task automatic full_frame(input bit rnd, input int idle);
        int s0 = strobes;
        send_frame(rnd, idle, -1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("strobes_per_frame", strobes - s0, ROWS*COLS);
        chk("queue_drained", q.size(), 0);
    endtask

    task automatic async_reset_check();
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rst_ready", ready_o, 1);
        chk("rst_done", done_o, 0);
        chk("rst_data", {d0_o, d1_o, d2_o}, 0);
        @(posedge clk); #1;
        q.delete();
        low_run = 0;
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("init_ready", ready_o, 1);
        chk("init_done", done_o, 0);
        chk("init_data", {d0_o, d1_o, d2_o}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        full_frame(1'b0, 0);                // continuous 16*row+col frame
        full_frame(1'b0, 30);               // same pattern with idle gaps
        full_frame(1'b1, 30);
        full_frame(1'b1, 30);

        send_frame(1'b0, 0, 2*COLS + 2, 1'b0);  // stop after row 2 col 1
        async_reset_check();
        full_frame(1'b0, 0);                // stale RAM must not leak into row 1

`ifdef SOBEL_LB_FRAME_SYNC_EN
        send_frame(1'b1, 0, 6, 1'b0);       // partial frame, aborted by sof
        repeat (2) @(posedge clk);
        #1;
        chk("partial_drained", q.size(), 0);
        begin
            int s0 = strobes;
            send_frame(1'b0, 10, -1, 1'b1);
            repeat (2) @(posedge clk);
            #1;
            chk("sof_frame_strobes", strobes - s0, ROWS*COLS);
        end
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("final_queue", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
